// File: rtl/scr1_clk_ctrl_pkg.sv
// Shared types and constants for the core clock-enable controller.
// The optional sleep statistics counter is enabled by SCR1_CLK_CTRL_STATS_EN.
package scr1_clk_ctrl_pkg;

   // Width of the optional sleep-cycle statistics counter
   localparam int SCR1_CLK_CTRL_STATS_W = 32;

   // Controller states: running, counting idle hysteresis, clock stopped, settling after wake
   typedef enum logic [1:0] {
      RUN       = 2'd0,
      IDLE_WAIT = 2'd1,
      SLEEP     = 2'd2,
      WAKE      = 2'd3
   } type_scr1_clk_ctrl_state_e;

endpackage

// File: rtl/scr1_clk_ctrl.sv
// Core clock-enable controller: decides when the gated core clock may stop,
// applies idle hysteresis before stopping and a settle window after waking,
// and reports sleep status back to the core. Runs on the free-running clock.
// Optional feature macro: SCR1_CLK_CTRL_STATS_EN adds a saturating 32-bit
// sleep-cycle counter (sleep_cnt) with a synchronous clear (sleep_cnt_clr).
module scr1_clk_ctrl
   import scr1_clk_ctrl_pkg::*;
#(
   parameter int HYST_CYCLES = 4,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic sleep_req,
   input  logic core_idle,
   input  logic wake_pending,
   input  logic dbg_req,
   output logic clk_en,
   output logic sleep_ack,
   output logic ctrl_busy
`ifdef SCR1_CLK_CTRL_STATS_EN
   ,
   input  logic                             sleep_cnt_clr,
   output logic [SCR1_CLK_CTRL_STATS_W-1:0] sleep_cnt
`endif
);

   // Reject counter settings the internal counter cannot represent
   if (HYST_CYCLES < 1 || HYST_CYCLES > (2**CNT_W) - 1) begin : g_hyst_chk
      $error("scr1_clk_ctrl: HYST_CYCLES out of range for CNT_W");
   end
   if (WAKE_CYCLES < 1 || WAKE_CYCLES > (2**CNT_W) - 1) begin : g_wake_chk
      $error("scr1_clk_ctrl: WAKE_CYCLES out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] HYST_LIMIT = CNT_W'(HYST_CYCLES);
   localparam logic [CNT_W-1:0] WAKE_LIMIT = CNT_W'(WAKE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   type_scr1_clk_ctrl_state_e state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      clk_en_q, clk_en_d;
   logic                      sleep_ack_q, sleep_ack_d;
   logic                      ctrl_busy_q, ctrl_busy_d;
   logic                      qual;
   logic                      wake_evt;

   // Sleep is allowed only while the core asks for it, is idle, and no wake source is active;
   // a withdrawn sleep request counts as a wake just like an IRQ or debug request
   always_comb begin
      qual     = sleep_req & core_idle & ~wake_pending & ~dbg_req;
      wake_evt = wake_pending | dbg_req | ~sleep_req;
   end

   // Next-state and counter logic; an abort in IDLE_WAIT is checked before expiry so a
   // wake source arriving on the expiry cycle keeps the clock running
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (qual) begin
               state_d = IDLE_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         IDLE_WAIT: begin
            if (!qual) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (cnt_q == HYST_LIMIT) begin
               state_d = SLEEP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         SLEEP: begin
            if (wake_evt) begin
               state_d = WAKE;
               cnt_d   = CNT_ONE;
            end
         end
         WAKE: begin
            if (cnt_q == WAKE_LIMIT) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from the current state; registered so no input reaches an output combinationally
   always_comb begin
      clk_en_d    = (state_q != SLEEP);
      sleep_ack_d = (state_q == SLEEP) || (state_q == WAKE);
      ctrl_busy_d = (state_q != RUN);
   end

   // State, counter and output registers; reset re-enables the clock with no wake window
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         clk_en_q    <= 1'b1;
         sleep_ack_q <= 1'b0;
         ctrl_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         clk_en_q    <= clk_en_d;
         sleep_ack_q <= sleep_ack_d;
         ctrl_busy_q <= ctrl_busy_d;
      end
   end

   assign clk_en    = clk_en_q;
   assign sleep_ack = sleep_ack_q;
   assign ctrl_busy = ctrl_busy_q;

`ifdef SCR1_CLK_CTRL_STATS_EN
   logic [SCR1_CLK_CTRL_STATS_W-1:0] sleep_cnt_q, sleep_cnt_d;

   // Count cycles spent in SLEEP, saturating at all-ones; a clear beats a same-cycle increment
   always_comb begin
      sleep_cnt_d = sleep_cnt_q;
      if (sleep_cnt_clr) begin
         sleep_cnt_d = '0;
      end else if ((state_q == SLEEP) && (sleep_cnt_q != '1)) begin
         sleep_cnt_d = sleep_cnt_q + 1'b1;
      end
   end

   // Statistics register
   always_ff @(posedge clk) begin
      if (rst) begin
         sleep_cnt_q <= '0;
      end else begin
         sleep_cnt_q <= sleep_cnt_d;
      end
   end

   assign sleep_cnt = sleep_cnt_q;
`endif

endmodule

// File: tb/tb_scr1_clk_ctrl.sv
// Directed testbench for scr1_clk_ctrl with HYST_CYCLES=4, WAKE_CYCLES=2.
// Cycle c is the interval after the c-th rising edge counted from where a
// scenario starts driving; outputs are sampled on the falling edge.
// Statistics checks are compiled only when SCR1_CLK_CTRL_STATS_EN is defined.
module tb_scr1_clk_ctrl;

   logic clk;
   logic rst;
   logic sleep_req;
   logic core_idle;
   logic wake_pending;
   logic dbg_req;
   logic clk_en;
   logic sleep_ack;
   logic ctrl_busy;
`ifdef SCR1_CLK_CTRL_STATS_EN
   logic        sleep_cnt_clr;
   logic [31:0] sleep_cnt;
`endif

   int   total;
   int   bad;
   logic exp_en;
   logic exp_ack;
   logic exp_busy;

   scr1_clk_ctrl #(
      .HYST_CYCLES (4),
      .WAKE_CYCLES (2),
      .CNT_W       (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sleep_req     (sleep_req),
      .core_idle     (core_idle),
      .wake_pending  (wake_pending),
      .dbg_req       (dbg_req),
      .clk_en        (clk_en),
      .sleep_ack     (sleep_ack),
      .ctrl_busy     (ctrl_busy)
`ifdef SCR1_CLK_CTRL_STATS_EN
      ,
      .sleep_cnt_clr (sleep_cnt_clr),
      .sleep_cnt     (sleep_cnt)
`endif
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drop every request and let the controller settle back into RUN
   task automatic go_idle;
      sleep_req    = 1'b0;
      core_idle    = 1'b0;
      wake_pending = 1'b0;
      dbg_req      = 1'b0;
`ifdef SCR1_CLK_CTRL_STATS_EN
      sleep_cnt_clr = 1'b0;
`endif
      repeat (8) @(negedge clk);
   endtask

   // Reset values held during and just after reset
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (clk_en !== 1'b1) begin bad++; $display("[TB] FAIL reset_clk_en got=%b exp=1", clk_en); end
      total++; if (sleep_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_sleep_ack got=%b exp=0", sleep_ack); end
      total++; if (ctrl_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_ctrl_busy got=%b exp=0", ctrl_busy); end
`ifdef SCR1_CLK_CTRL_STATS_EN
      total++; if (sleep_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_sleep_cnt got=%0d exp=0", sleep_cnt); end
`endif
      rst = 1'b0;
      @(negedge clk);
      total++; if (clk_en !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_clk_en got=%b exp=1", clk_en); end
      total++; if (ctrl_busy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_busy got=%b exp=0", ctrl_busy); end
   endtask

   // Steady qualification: busy from cycle 2, clock stops at cycle 6
   task automatic test_basic_sleep;
      sleep_req = 1'b1;
      core_idle = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         exp_en   = (i < 6);
         exp_ack  = (i >= 6);
         exp_busy = (i >= 2);
         total++; if (clk_en !== exp_en) begin bad++; $display("[TB] FAIL basic_clk_en cyc=%0d got=%b exp=%b", i, clk_en, exp_en); end
         total++; if (sleep_ack !== exp_ack) begin bad++; $display("[TB] FAIL basic_sleep_ack cyc=%0d got=%b exp=%b", i, sleep_ack, exp_ack); end
         total++; if (ctrl_busy !== exp_busy) begin bad++; $display("[TB] FAIL basic_busy cyc=%0d got=%b exp=%b", i, ctrl_busy, exp_busy); end
      end
   endtask

   // IRQ pulse at cycle T while sleeping: clk_en back at T+2, sleep_ack low at T+4;
   // a second pulse at T+2 lands in WAKE and must not stretch the window
   task automatic test_wake_irq;
      wake_pending = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         exp_en  = (i >= 2);
         exp_ack = (i <= 3);
         total++; if (clk_en !== exp_en) begin bad++; $display("[TB] FAIL wake_clk_en T+%0d got=%b exp=%b", i, clk_en, exp_en); end
         total++; if (sleep_ack !== exp_ack) begin bad++; $display("[TB] FAIL wake_sleep_ack T+%0d got=%b exp=%b", i, sleep_ack, exp_ack); end
         if (i <= 4) begin
            exp_busy = (i <= 3);
            total++; if (ctrl_busy !== exp_busy) begin bad++; $display("[TB] FAIL wake_busy T+%0d got=%b exp=%b", i, ctrl_busy, exp_busy); end
         end
         wake_pending = (i == 2);
      end
   endtask

   // core_idle drops for one cycle at cycle 3: back to RUN, count restarts, clock stops at cycle 10
   task automatic test_hyst_abort;
      sleep_req = 1'b1;
      core_idle = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         exp_en   = (i < 10);
         exp_busy = ((i >= 2) && (i <= 4)) || (i >= 6);
         total++; if (clk_en !== exp_en) begin bad++; $display("[TB] FAIL abort_clk_en cyc=%0d got=%b exp=%b", i, clk_en, exp_en); end
         total++; if (ctrl_busy !== exp_busy) begin bad++; $display("[TB] FAIL abort_busy cyc=%0d got=%b exp=%b", i, ctrl_busy, exp_busy); end
         if (i == 3) core_idle = 1'b0;
         if (i == 4) core_idle = 1'b1;
      end
   endtask

   // dbg_req arrives in the IDLE_WAIT cycle where the count has reached HYST_CYCLES (cycle 4)
   task automatic test_race_expiry;
      sleep_req = 1'b1;
      core_idle = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         exp_busy = (i >= 2) && (i <= 5);
         total++; if (clk_en !== 1'b1) begin bad++; $display("[TB] FAIL race_clk_en cyc=%0d got=%b exp=1", i, clk_en); end
         total++; if (sleep_ack !== 1'b0) begin bad++; $display("[TB] FAIL race_sleep_ack cyc=%0d got=%b exp=0", i, sleep_ack); end
         total++; if (ctrl_busy !== exp_busy) begin bad++; $display("[TB] FAIL race_busy cyc=%0d got=%b exp=%b", i, ctrl_busy, exp_busy); end
         if (i == 4) dbg_req = 1'b1;
         if (i == 5) begin
            dbg_req   = 1'b0;
            sleep_req = 1'b0;
         end
      end
   endtask

   // One-cycle reset while asleep: clock back immediately with no wake window
   task automatic test_reset_mid_sleep;
      sleep_req = 1'b1;
      core_idle = 1'b1;
      repeat (7) @(negedge clk);
      total++; if (clk_en !== 1'b0) begin bad++; $display("[TB] FAIL rstsleep_pre_clk_en got=%b exp=0", clk_en); end
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      sleep_req = 1'b0;
      core_idle = 1'b0;
      total++; if (clk_en !== 1'b1) begin bad++; $display("[TB] FAIL rstsleep_clk_en got=%b exp=1", clk_en); end
      total++; if (sleep_ack !== 1'b0) begin bad++; $display("[TB] FAIL rstsleep_sleep_ack got=%b exp=0", sleep_ack); end
      total++; if (ctrl_busy !== 1'b0) begin bad++; $display("[TB] FAIL rstsleep_busy got=%b exp=0", ctrl_busy); end
`ifdef SCR1_CLK_CTRL_STATS_EN
      total++; if (sleep_cnt !== 32'd0) begin bad++; $display("[TB] FAIL rstsleep_sleep_cnt got=%0d exp=0", sleep_cnt); end
`endif
      @(negedge clk);
      total++; if (sleep_ack !== 1'b0) begin bad++; $display("[TB] FAIL rstsleep_next_ack got=%b exp=0", sleep_ack); end
      total++; if (ctrl_busy !== 1'b0) begin bad++; $display("[TB] FAIL rstsleep_next_busy got=%b exp=0", ctrl_busy); end
   endtask

`ifdef SCR1_CLK_CTRL_STATS_EN
   // SLEEP from cycle 5: 10 counted cycles by cycle 15, clear beats increment, saturation at all-ones
   task automatic test_stats;
      sleep_cnt_clr = 1'b1;
      @(negedge clk);
      sleep_cnt_clr = 1'b0;
      sleep_req     = 1'b1;
      core_idle     = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 5) begin
            total++; if (sleep_cnt !== 32'd0) begin bad++; $display("[TB] FAIL stats_start got=%0d exp=0", sleep_cnt); end
         end
      end
      total++; if (sleep_cnt !== 32'd10) begin bad++; $display("[TB] FAIL stats_ten got=%0d exp=10", sleep_cnt); end
      sleep_cnt_clr = 1'b1;
      @(negedge clk);
      sleep_cnt_clr = 1'b0;
      total++; if (sleep_cnt !== 32'd0) begin bad++; $display("[TB] FAIL stats_clear got=%0d exp=0", sleep_cnt); end
      @(negedge clk);
      total++; if (sleep_cnt !== 32'd1) begin bad++; $display("[TB] FAIL stats_after_clear got=%0d exp=1", sleep_cnt); end
      force dut.sleep_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.sleep_cnt_q;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         total++; if (sleep_cnt !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL stats_saturate step=%0d got=%h exp=ffffffff", i, sleep_cnt); end
      end
   endtask
`endif

   // Scenario sequence and summary
   initial begin
      total        = 0;
      bad          = 0;
      rst          = 1'b1;
      sleep_req    = 1'b0;
      core_idle    = 1'b0;
      wake_pending = 1'b0;
      dbg_req      = 1'b0;
`ifdef SCR1_CLK_CTRL_STATS_EN
      sleep_cnt_clr = 1'b0;
`endif
      test_reset();
      test_basic_sleep();
      test_wake_irq();
      go_idle();
      test_hyst_abort();
      go_idle();
      test_race_expiry();
      go_idle();
      test_reset_mid_sleep();
      go_idle();
`ifdef SCR1_CLK_CTRL_STATS_EN
      test_stats();
      go_idle();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
